// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end: synchronise and filter the bus, frame bytes, and track held keys.
// Optional build macro PS2_RELEASE_ON_ERROR_EN drops all held keys on any frame error.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys_1,
  output logic       keypressed_1,
  output logic [3:0] keys_2,
  output logic       keypressed_2,
  output logic       frame_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic           r_filt;
  logic [FCW-1:0] r_fcnt;
  logic           r_strobe;

  state_e         r_state, w_state_d;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic           r_par;
  logic [TCW-1:0] r_to_cnt;
  logic           r_byte_valid;
  logic [7:0]     r_byte;
  logic           r_frame_err;

  logic           r_ext, r_brk, w_ext_d, w_brk_d;
  logic [3:0]     r_keys1, r_keys2, w_keys1_d, w_keys2_d;
  logic           r_kp1, r_kp2;

  logic           w_timeout, w_start, w_shift, w_par_ld, w_stop, w_frame_ok, w_err;

  // Synchronisers idle high, matching an undriven PS/2 bus.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
          r_filt   <= r_clk_s2;
          r_fcnt   <= '0;
          r_strobe <= ~r_clk_s2;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  // Frame FSM: state register
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Frame FSM: next state
  always_comb begin
    w_state_d = r_state;
    if (w_timeout) begin
      w_state_d = StIdle;
    end else if (r_strobe) begin
      unique case (r_state)
        StIdle:   if (!r_dat_s2) w_state_d = StData;
        StData:   if (r_bit_cnt == 3'd7) w_state_d = StParity;
        StParity: w_state_d = StStop;
        StStop:   w_state_d = StIdle;
        default:  w_state_d = StIdle;
      endcase
    end
  end

  // Frame FSM: outputs
  always_comb begin
    w_timeout  = (r_state != StIdle) && !r_strobe && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));
    w_start    = r_strobe && (r_state == StIdle) && !r_dat_s2;
    w_shift    = r_strobe && (r_state == StData);
    w_par_ld   = r_strobe && (r_state == StParity);
    w_stop     = r_strobe && (r_state == StStop);
    w_frame_ok = w_stop && r_dat_s2 && (^{r_shift, r_par});
    w_err      = w_timeout || (w_stop && !w_frame_ok);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {r_dat_s2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_par_ld) begin
        r_par <= r_dat_s2;
      end
      // A strobe in the timeout cycle wins: the counter simply clears.
      if ((r_state == StIdle) || r_strobe || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      r_byte_valid <= w_frame_ok;
      if (w_frame_ok) begin
        r_byte <= r_shift;
      end
      r_frame_err <= w_err;
    end
  end

  always_comb begin
    w_keys1_d = r_keys1;
    w_keys2_d = r_keys2;
    w_ext_d   = r_ext;
    w_brk_d   = r_brk;
    if (w_err) begin
      w_ext_d = 1'b0;
      w_brk_d = 1'b0;
`ifdef PS2_RELEASE_ON_ERROR_EN
      w_keys1_d = '0;
      w_keys2_d = '0;
`endif
    end else if (r_byte_valid) begin
      if (r_byte == 8'hE0) begin
        w_ext_d = 1'b1;
      end else if (r_byte == 8'hF0) begin
        w_brk_d = 1'b1;
      end else begin
        w_ext_d = 1'b0;
        w_brk_d = 1'b0;
        case ({r_ext, r_byte})
          9'h01D:  w_keys1_d[0] = ~r_brk;
          9'h01B:  w_keys1_d[1] = ~r_brk;
          9'h023:  w_keys1_d[2] = ~r_brk;
          9'h015:  w_keys1_d[3] = ~r_brk;
          9'h175:  w_keys2_d[0] = ~r_brk;
          9'h172:  w_keys2_d[1] = ~r_brk;
          9'h174:  w_keys2_d[2] = ~r_brk;
          9'h04D:  w_keys2_d[3] = ~r_brk;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_keys1 <= '0;
      r_keys2 <= '0;
      r_kp1   <= 1'b0;
      r_kp2   <= 1'b0;
    end else begin
      r_ext   <= w_ext_d;
      r_brk   <= w_brk_d;
      r_keys1 <= w_keys1_d;
      r_keys2 <= w_keys2_d;
      r_kp1   <= |w_keys1_d;
      r_kp2   <= |w_keys2_d;
    end
  end

  assign keys_1       = r_keys1;
  assign keys_2       = r_keys2;
  assign keypressed_1 = r_kp1;
  assign keypressed_2 = r_kp2;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed-frame bench for ps2_key_decoder; a held-key model is checked every quiet cycle.
// Expectations follow PS2_RELEASE_ON_ERROR_EN when that macro is defined.
module tb_ps2_key_decoder;

  localparam int TO     = 25000;
  localparam int FL     = 8;
  localparam int HALF   = 20;
  localparam int SETTLE = 30;

  logic       CLOCK_25 = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys_1, keys_2;
  logic       keypressed_1, keypressed_2, frame_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  bit m_valid  = 1'b0;

  bit [3:0] m_k1 = '0;
  bit [3:0] m_k2 = '0;
  bit       m_ext = 1'b0;
  bit       m_brk = 1'b0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keys_1      (keys_1),
    .keypressed_1(keypressed_1),
    .keys_2      (keys_2),
    .keypressed_2(keypressed_2),
    .frame_err   (frame_err)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key table: index 0..3 player 1, 4..7 player 2.
  function automatic int key_of(input bit ext, input logic [7:0] b);
    if (!ext && b == 8'h1D) return 0;
    if (!ext && b == 8'h1B) return 1;
    if (!ext && b == 8'h23) return 2;
    if (!ext && b == 8'h15) return 3;
    if (ext && b == 8'h75)  return 4;
    if (ext && b == 8'h72)  return 5;
    if (ext && b == 8'h74)  return 6;
    if (!ext && b == 8'h4D) return 7;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = key_of(m_ext, b);
      if (k >= 4) m_k2[k-4] = !m_brk;
      else if (k >= 0) m_k1[k] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
`ifdef PS2_RELEASE_ON_ERROR_EN
    m_k1 = '0;
    m_k2 = '0;
`endif
  endtask

  always @(negedge CLOCK_25) if (frame_err) err_cnt++;

  initial begin
    forever begin
      @(posedge CLOCK_25);
      #1;
      if (m_valid) begin
        chk("keys_1", keys_1, m_k1);
        chk("keys_2", keys_2, m_k2);
        chk("keypressed_1", keypressed_1, |m_k1);
        chk("keypressed_2", keypressed_2, |m_k2);
        chk("frame_err_quiet", frame_err, 0);
      end
    end
  end

  task automatic ps2_bit(input bit v);
    @(negedge CLOCK_25) ps2_data = v;
    repeat (HALF) @(negedge CLOCK_25);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge CLOCK_25);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int e0;
    m_valid = 1'b0;
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (SETTLE) @(negedge CLOCK_25);
    chk("frame_err_pulses", err_cnt - e0, (bad_par || bad_stop) ? 1 : 0);
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
    m_valid = 1'b1;
  endtask

  task automatic timeout_test();
    int n;
    bit got;
    m_valid = 1'b0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge CLOCK_25) ps2_data = 1'b0;
    repeat (HALF) @(negedge CLOCK_25);
    ps2_clk = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < TO + FL + 20) begin
      @(negedge CLOCK_25);
      n++;
      if (n == HALF) begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
      end
      if (frame_err) got = 1'b1;
    end
    chk("timeout_fired", got, 1);
    chk("timeout_not_early", n >= TO, 1);
    chk("timeout_not_late", n <= TO + FL + 6, 1);
    repeat (SETTLE) @(negedge CLOCK_25);
    model_err();
    m_valid = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge CLOCK_25);
    chk("rst_keys_1", keys_1, 0);
    chk("rst_keys_2", keys_2, 0);
    chk("rst_kp_1", keypressed_1, 0);
    chk("rst_kp_2", keypressed_2, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_25);
    m_valid = 1'b1;

    send_frame(8'h1D, 0, 0);
    chk("w_make_keys_1", keys_1, 4'b0001);
    chk("w_make_kp_1", keypressed_1, 1);
    chk("w_make_keys_2", keys_2, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);
    chk("w_break_keys_1", keys_1, 0);
    chk("w_break_kp_1", keypressed_1, 0);

    send_frame(8'hE0, 0, 0);
    send_frame(8'h72, 0, 0);
    chk("ext72_make", keys_2, 4'b0010);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h72, 0, 0);
    chk("ext72_break", keys_2, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h72, 0, 0);
    send_frame(8'h72, 0, 0);
    chk("plain72_ignored", keys_2, 4'b0010);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    chk("f0_e0_order", keys_2, 4'b0010);

    send_frame(8'h4D, 0, 0);
    send_frame(8'h1D, 0, 0);
    send_frame(8'h1D, 0, 0);
    chk("typematic_keys_1", keys_1, 4'b0001);
    chk("p_pause_keys_2", keys_2, 4'b1010);

    send_frame(8'h1B, 1, 0);
`ifdef PS2_RELEASE_ON_ERROR_EN
    chk("bad_parity_keys_1", keys_1, 0);
`else
    chk("bad_parity_keys_1", keys_1, 4'b0001);
`endif
    send_frame(8'h15, 0, 1);

    timeout_test();
    send_frame(8'h23, 0, 0);
    chk("after_timeout_serve", keys_1[2], 1);

    @(negedge CLOCK_25);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge CLOCK_25);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (SETTLE) @(negedge CLOCK_25);
    send_frame(8'h1B, 0, 0);
    chk("after_glitch_down", keys_1[1], 1);

    m_valid = 1'b0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge CLOCK_25) reset = 1'b1;
    @(posedge CLOCK_25);
    #1;
    chk("midrst_keys_1", keys_1, 0);
    chk("midrst_keys_2", keys_2, 0);
    chk("midrst_kp_1", keypressed_1, 0);
    chk("midrst_kp_2", keypressed_2, 0);
    chk("midrst_frame_err", frame_err, 0);
    @(negedge CLOCK_25) reset = 1'b0;
    ps2_data = 1'b1;
    m_k1  = '0;
    m_k2  = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(negedge CLOCK_25);
    m_valid = 1'b1;
    send_frame(8'h1D, 0, 0);
    chk("after_reset_w", keys_1, 4'b0001);

    repeat (10) @(negedge CLOCK_25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
